// File: rtl/hdu_pkg.sv
// Shared types and defaults for the hazard-detection scoreboard.
package hdu_pkg;

   localparam int HDU_REG_ADDR_W = 5;
   localparam int HDU_DEPTH      = 4;
   localparam int HDU_TAG_W      = $clog2(HDU_DEPTH);

   typedef logic [HDU_TAG_W-1:0] tag_t;

   typedef struct packed {
      logic                      valid;
      logic [HDU_REG_ADDR_W-1:0] rd;
   } sb_entry_t;

   // x0 is hard-wired, so a zero address never creates a dependency.
   function automatic logic reg_match(input logic [HDU_REG_ADDR_W-1:0] a,
                                      input logic [HDU_REG_ADDR_W-1:0] b);
      return (a != {HDU_REG_ADDR_W{1'b0}}) && (a == b);
   endfunction

endpackage

// File: rtl/hdu_free_pick.sv
// Lowest-index free-entry priority encoder for the scoreboard table.
module hdu_free_pick #(
   parameter int DEPTH = 4,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] free,
   output logic [TAG_W-1:0] idx,
   output logic             any_free
);

   // scan upward, first free slot wins; idx stays 0 when nothing is free
   always_comb begin
      idx      = {TAG_W{1'b0}};
      any_free = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (free[i] && !any_free) begin
            idx      = TAG_W'(i);
            any_free = 1'b1;
         end else begin
            any_free = any_free;
         end
      end
   end

endmodule

// File: rtl/hdu_scoreboard.sv
// Dispatch-stage scoreboard tracking long-latency destinations until write-back.
// Optional HDU_WB_BYPASS_EN: a completing entry stops counting in its write-back cycle.
module hdu_scoreboard
   import hdu_pkg::*;
#(
   parameter int REG_ADDR_W = HDU_REG_ADDR_W,
   parameter int DEPTH      = HDU_DEPTH,
   parameter int TAG_W      = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_valid_i,
   input  logic [REG_ADDR_W-1:0] issue_rs1_addr_i,
   input  logic [REG_ADDR_W-1:0] issue_rs2_addr_i,
   input  logic                  issue_rs1_re_i,
   input  logic                  issue_rs2_re_i,
   input  logic [REG_ADDR_W-1:0] issue_rd_addr_i,
   input  logic                  issue_rd_we_i,
   input  logic                  issue_long_i,
   input  logic                  dispatch_stall_i,
   input  logic                  flush_i,
   input  logic                  wb_valid_i,
   input  logic [TAG_W-1:0]      wb_tag_i,
   output logic                  stall_flag_o,
   output logic [TAG_W-1:0]      issue_tag_o,
   output logic [TAG_W:0]        pending_cnt_o,
   output logic                  err_o
);

   sb_entry_t [DEPTH-1:0] entries;
   sb_entry_t [DEPTH-1:0] entries_next;

   logic [DEPTH-1:0] wb_hit;
   logic [DEPTH-1:0] active;
   logic [DEPTH-1:0] hit;
   logic [DEPTH-1:0] free_mask;
   logic [TAG_W-1:0] pick_idx;
   logic [TAG_W:0]   cnt_next;
   logic             any_free;
   logic             hazard;
   logic             full;
   logic             fire;
   logic             alloc;
   logic             err_next;

   for (genvar e = 0; e < DEPTH; e++) begin : g_entry
`ifdef HDU_WB_BYPASS_EN
      assign wb_hit[e] = wb_valid_i & (wb_tag_i == TAG_W'(e));
`else
      assign wb_hit[e] = 1'b0;
`endif
      assign active[e] = entries[e].valid & ~wb_hit[e];
      assign hit[e]    = active[e] &
                         ((issue_rs1_re_i & reg_match(issue_rs1_addr_i, entries[e].rd)) |
                          (issue_rs2_re_i & reg_match(issue_rs2_addr_i, entries[e].rd)) |
                          (issue_rd_we_i  & reg_match(issue_rd_addr_i,  entries[e].rd)));
   end

   // Without bypass active == valid, so only registered-free slots are offered.
   assign free_mask = ~active;

   hdu_free_pick #(
      .DEPTH (DEPTH),
      .TAG_W (TAG_W)
   ) u_free_pick (
      .free     (free_mask),
      .idx      (pick_idx),
      .any_free (any_free)
   );

   assign hazard = |hit;
   assign full   = &active;

   // Stall must not depend on dispatch_stall_i/flush_i to keep the control loop acyclic.
   assign stall_flag_o = issue_valid_i & (hazard | (issue_long_i & issue_rd_we_i & full));
   assign fire         = issue_valid_i & ~stall_flag_o & ~dispatch_stall_i & ~flush_i;
   assign alloc        = fire & issue_long_i & issue_rd_we_i & any_free &
                         (issue_rd_addr_i != {REG_ADDR_W{1'b0}});
   assign issue_tag_o  = pick_idx;

   // completion clears first so a same-slot allocation (bypass) wins
   always_comb begin
      entries_next = entries;
      err_next     = err_o;
      if (wb_valid_i) begin
         if (entries[wb_tag_i].valid) begin
            entries_next[wb_tag_i].valid = 1'b0;
         end else begin
            err_next = 1'b1;
         end
      end else begin
         err_next = err_o;
      end
      if (alloc) begin
         entries_next[pick_idx].valid = 1'b1;
         entries_next[pick_idx].rd    = issue_rd_addr_i;
      end else begin
         entries_next[pick_idx] = entries_next[pick_idx];
      end
   end

   // population count of the next table, registered as pending_cnt_o
   always_comb begin
      cnt_next = {(TAG_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         cnt_next = cnt_next + (TAG_W+1)'(entries_next[i].valid);
      end
   end

   // table, occupancy count and sticky error state
   always_ff @(posedge clk) begin
      if (rst) begin
         entries       <= '0;
         pending_cnt_o <= {(TAG_W+1){1'b0}};
         err_o         <= 1'b0;
      end else begin
         entries       <= entries_next;
         pending_cnt_o <= cnt_next;
         err_o         <= err_next;
      end
   end

endmodule

// File: doc/hdu_scoreboard.md
# hdu_scoreboard

Hazard detection unit that tracks destination registers of issued long-latency instructions (loads, mul/div, atomics) until write-back. It drives the data-hazard stall into the pipeline control unit. That unit turns the stall into the pipeline stall/flush bus. Sits at dispatch: consumes decode-stage register addresses and write-back completions, produces `stall_flag_o` for the control unit's HDU stall input and a tag that travels with the instruction.

## Interface
Parameters:
- `REG_ADDR_W`, 5, register-file address width
- `DEPTH`, 4, outstanding long-latency entries (power of two, ≥2)
- `TAG_W`, $clog2(DEPTH), entry tag width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `issue_valid_i`  in  1  decode presents an instruction
- `issue_rs1_addr_i` / `issue_rs2_addr_i`  in  REG_ADDR_W  source registers
- `issue_rs1_re_i` / `issue_rs2_re_i`  in  1  source actually read
- `issue_rd_addr_i`  in  REG_ADDR_W  destination register
- `issue_rd_we_i`  in  1  destination written
- `issue_long_i`  in  1  instruction is long-latency (allocates entry)
- `dispatch_stall_i`  in  1  non-data-hazard stall (dispatch stall bit of control bus)
- `flush_i`  in  1  flush bit of control bus
- `wb_valid_i`  in  1  long-latency result written back this cycle
- `wb_tag_i`  in  TAG_W  tag of completing entry
- `stall_flag_o`  out  1  data-hazard stall to control unit
- `issue_tag_o`  out  TAG_W  tag allocated to current instruction
- `pending_cnt_o`  out  TAG_W+1  number of valid entries
- `err_o`  out  1  sticky: completion targeted a free entry

## Operation
- Entry = {valid, rd}. Hazard vs entry e: `valid[e]` and any of the following:
  - `rs1_re` and rs1==rd[e]
  - `rs2_re` and rs2==rd[e]
  - `rd_we` and rd==rd[e] (WAW)
- Address 0 never matches: x0 reads/writes are ignored.
- `stall_flag_o` = `issue_valid_i` & (any entry hazard | (`issue_long_i` & `issue_rd_we_i` & table full)).
- `stall_flag_o` is independent of `dispatch_stall_i` and `flush_i`; this avoids a combinational loop through the control unit.
- fire = `issue_valid_i` & ~`stall_flag_o` & ~`dispatch_stall_i` & ~`flush_i`.
- On fire with `issue_long_i` & `issue_rd_we_i` & rd≠0:
  - allocate the lowest-index free entry (free = ~valid, registered state only)
  - set valid, store rd
  - `issue_tag_o` = that index, valid combinationally in the same cycle
- When no entry is allocated, `issue_tag_o` is the lowest free index, or 0 if the table is full.
- On `wb_valid_i`:
  - clear `valid[wb_tag_i]`
  - if the entry is already free: no state change, set `err_o`
- Same-cycle alloc and completion: both apply. A slot freed this cycle is not re-allocated until the next cycle.
- `flush_i` blocks allocation only. Issued entries stay pending until write-back, because those instructions are past dispatch.
- `pending_cnt_o` = popcount(valid), registered.

## Timing
- Reset values: all `valid`=0; `err_o`=0; `pending_cnt_o`=0; `stall_flag_o`=0; `issue_tag_o`=0.
- Hazard/stall: combinational from inputs and registered table, 0-cycle latency.
- Allocation visible to hazard check one cycle after fire. A dependent instruction in the next cycle stalls.
- Completion visible one cycle after `wb_valid_i`. Without bypass, a dependent instruction issues no earlier than the cycle after write-back.
- Full: with DEPTH entries valid, a long-latency write instruction stalls. Non-long instructions without hazard still fire.
- Reset mid-operation clears all entries. In-flight completions after reset set `err_o`.

## Configuration
- `HDU_WB_BYPASS_EN` defined: an entry matching `wb_tag_i` with `wb_valid_i` high is excluded from the hazard and full checks in that cycle. This relies on the write-back→decode forwarding path, so the dependent instruction issues in the write-back cycle.
- `HDU_WB_BYPASS_EN` undefined: the completing entry still counts as pending in that cycle (one extra stall cycle).

## Structure
- Package `hdu_pkg`: `sb_entry_t` struct {valid, rd}, default `DEPTH`/`TAG_W` constants, tag typedef.
- Sub-module `hdu_free_pick`: lowest-index free-entry priority encoder (DEPTH-bit free mask → index + any_free).
- Hazard compare is a generate loop over entries in the top.

## Test plan
- Reset, then issue long load rd=5 (tag 0), next cycle add rs1=5 → `stall_flag_o`=1 until the cycle after `wb_valid_i`/`wb_tag_i`=0. With `HDU_WB_BYPASS_EN`, stall drops in the write-back cycle.
- Four long writes rd=1..4 with no write-back → tags 0,1,2,3, `pending_cnt_o`=4. Fifth long write rd=7 stalls; non-long add rd=9 rs=10,11 fires.
- Complete tag 2 while issuing long rd=8 in the same cycle, table full → stalls this cycle. Next cycle it fires with `issue_tag_o`=2.
- Long write rd=0, and read of rs1=0 with entry pending on rd=0 impossible → no allocation, no stall, `pending_cnt_o` unchanged.
- `flush_i`=1 or `dispatch_stall_i`=1 with valid long issue rd=6 → no allocation. Existing entry rd=3 remains, and rs2=3 still stalls afterward.
- `wb_valid_i` with `wb_tag_i`=1 while entry 1 free → `err_o`=1 and stays 1 until `rst`. Table unchanged.
